// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for 640x480@60 Hz VGA timing and frame-buffer
// geometry.
// Contents:
//   - H/V active, front-porch, sync, back-porch lengths and totals
//   - counter-width typed decode points used by the sync generator
//   - source frame width/height for the 1:1 and 2x-upscale modes
//   - sync polarity (active low)
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 800

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 525

  // Source frame-buffer geometry.
  localparam int SRC_W_1X = 640;
  localparam int SRC_H_1X = 480;
  localparam int SRC_W_2X = 320;
  localparam int SRC_H_2X = 240;

  // Both syncs are asserted low.
  localparam logic SYNC_ACTIVE = 1'b0;

  localparam int CNT_W = 10;
  typedef logic [CNT_W-1:0] cnt_t;

  // Decode points at counter width, so comparisons stay width-matched.
  localparam cnt_t H_ACT_C        = cnt_t'(H_ACTIVE);
  localparam cnt_t H_SYNC_START_C = cnt_t'(H_ACTIVE + H_FP);
  localparam cnt_t H_SYNC_END_C   = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam cnt_t H_LAST_C       = cnt_t'(H_TOTAL - 1);
  localparam cnt_t V_ACT_C        = cnt_t'(V_ACTIVE);
  localparam cnt_t V_SYNC_START_C = cnt_t'(V_ACTIVE + V_FP);
  localparam cnt_t V_SYNC_END_C   = cnt_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam cnt_t V_LAST_C       = cnt_t'(V_TOTAL - 1);

endpackage

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA h/v counters with raw (undelayed) decode.
// Ports:
//   i_clk         pixel clock
//   i_rst_n       asynchronous active-low reset, counters clear to (0,0)
//   o_h, o_v      current horizontal / vertical count
//   o_hsync       raw horizontal sync (active low)
//   o_vsync       raw vertical sync (active low)
//   o_active      (h,v) lies in the 640x480 visible region
//   o_line_wrap   h is at its last count; next cycle starts a new line
//   o_frame_wrap  line wrap on the last line; next cycle starts a new frame
module vga_sync_gen
  import vga_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  output cnt_t o_h,
  output cnt_t o_v,
  output logic o_hsync,
  output logic o_vsync,
  output logic o_active,
  output logic o_line_wrap,
  output logic o_frame_wrap
);

  cnt_t r_h;
  cnt_t r_v;
  cnt_t w_h_nxt;
  cnt_t w_v_nxt;
  logic w_line_wrap;
  logic w_frame_wrap;

  assign w_line_wrap  = (r_h == H_LAST_C);
  assign w_frame_wrap = w_line_wrap && (r_v == V_LAST_C);

  always_comb begin
    w_h_nxt = r_h + cnt_t'(1);
    w_v_nxt = r_v;
    if (w_line_wrap) begin
      w_h_nxt = '0;
      w_v_nxt = w_frame_wrap ? '0 : r_v + cnt_t'(1);
    end
  end

  // Both counters are written every cycle (hold comes from the next-state
  // logic), keeping the register update uniform.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h_nxt;
      r_v <= w_v_nxt;
    end
  end

  assign o_h          = r_h;
  assign o_v          = r_v;
  assign o_active     = (r_h < H_ACT_C) && (r_v < V_ACT_C);
  assign o_hsync      = ((r_h >= H_SYNC_START_C) && (r_h < H_SYNC_END_C)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign o_vsync      = ((r_v >= V_SYNC_START_C) && (r_v < V_SYNC_END_C)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  assign o_line_wrap  = w_line_wrap;
  assign o_frame_wrap = w_frame_wrap;

endmodule

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: 640x480@60 Hz VGA timing plus raster-order frame-buffer
// read addressing. Sync/blank are delayed by the frame-buffer read latency so
// they line up with the RGB word that comes back for each address.
//
// Optional feature macro: VGA_UPSCALE2X_EN
//   defined   : 320x240 source, each address issued for 2 pixels and each
//               source line read on 2 display lines (last address 76799)
//   undefined : 640x480 source read 1:1 (last address 307199)
//
// Parameters:
//   RD_LAT  frame-buffer read latency in clocks (1..3)
//   ADDR_W  rdaddr width (>=17 upscaled, >=19 1:1)
// Ports:
//   clk          25 MHz pixel clock
//   rst_n        asynchronous active-low reset
//   rdaddr       frame-buffer read address, qualified only by rden
//   rden         read enable, high for visible-region addresses
//   Nblank       display valid, aligned with returned frame-buffer data
//   hsync        horizontal sync (active low), aligned with Nblank
//   vsync        vertical sync (active low), aligned with Nblank
//   frame_start  one-cycle pulse together with the rden of address 0
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rdaddr,
  output logic              rden,
  output logic              Nblank,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);

  // rden is one stage behind the counters; sync/blank need RD_LAT more.
  localparam int DLY = RD_LAT + 1;

  cnt_t w_h;
  cnt_t w_v;
  logic w_hsync;
  logic w_vsync;
  logic w_active;
  logic w_line_wrap;
  logic w_frame_wrap;

  vga_sync_gen u_sync (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .o_h          (w_h),
    .o_v          (w_v),
    .o_hsync      (w_hsync),
    .o_vsync      (w_vsync),
    .o_active     (w_active),
    .o_line_wrap  (w_line_wrap),
    .o_frame_wrap (w_frame_wrap)
  );

  // ---------------------------------------------------------------------
  // Address generation: an incrementing address plus a per-line base,
  // so no multiplier is needed.
  // ---------------------------------------------------------------------
`ifdef VGA_UPSCALE2X_EN
  localparam int SRC_W = SRC_W_2X;
  logic w_addr_step;
  logic w_base_step;
  // Step after the odd pixel of each pair; advance the base after the odd
  // line of each pair, so every source line is read twice.
  assign w_addr_step = w_active & w_h[0];
  assign w_base_step = w_v[0];
`else
  localparam int SRC_W = SRC_W_1X;
  logic w_addr_step;
  logic w_base_step;
  assign w_addr_step = w_active;
  assign w_base_step = 1'b1;
`endif

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_line_base;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [ADDR_W-1:0] w_line_base_nxt;
  logic              w_line_active;

  assign w_line_active = (w_v < V_ACT_C);

  always_comb begin
    w_line_base_nxt = r_line_base;
    w_addr_nxt      = r_addr;
    if (w_frame_wrap) begin
      w_line_base_nxt = '0;
      w_addr_nxt      = '0;
    end else if (w_line_wrap) begin
      if (w_line_active && w_base_step) begin
        w_line_base_nxt = r_line_base + ADDR_W'(SRC_W);
      end
      w_addr_nxt = w_line_base_nxt;
    end else if (w_addr_step) begin
      w_addr_nxt = r_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_line_base <= '0;
    end else begin
      r_addr      <= w_addr_nxt;
      r_line_base <= w_line_base_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Read-side registers. rdaddr only updates on visible pixels and holds
  // its last value through blanking.
  // ---------------------------------------------------------------------
  logic [ADDR_W-1:0] r_rdaddr;
  logic              r_rden;
  logic              r_frame_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdaddr      <= '0;
      r_rden        <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      if (w_active) begin
        r_rdaddr <= r_addr;
      end
      r_rden        <= w_active;
      r_frame_start <= (w_h == '0) && (w_v == '0);
    end
  end

  // ---------------------------------------------------------------------
  // Sync/blank delay line. Resets to the inactive pattern so no sync pulse
  // or blank edge leaks out while the pipeline refills after reset.
  // ---------------------------------------------------------------------
  logic [DLY-1:0] r_hs_sr;
  logic [DLY-1:0] r_vs_sr;
  logic [DLY-1:0] r_nb_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hs_sr <= {DLY{~SYNC_ACTIVE}};
      r_vs_sr <= {DLY{~SYNC_ACTIVE}};
      r_nb_sr <= '0;
    end else begin
      r_hs_sr <= {r_hs_sr[DLY-2:0], w_hsync};
      r_vs_sr <= {r_vs_sr[DLY-2:0], w_vsync};
      r_nb_sr <= {r_nb_sr[DLY-2:0], w_active};
    end
  end

  assign rdaddr      = r_rdaddr;
  assign rden        = r_rden;
  assign frame_start = r_frame_start;
  assign hsync       = r_hs_sr[DLY-1];
  assign vsync       = r_vs_sr[DLY-1];
  assign Nblank      = r_nb_sr[DLY-1];

endmodule

// File: tb/tb_vga_frame_reader.sv
// tb_vga_frame_reader: directed bench for vga_frame_reader.
// dut_a (RD_LAT=1) is scanned for line/frame timing and read addresses;
// dut_b (RD_LAT=3) takes an asynchronous reset in the middle of a line.
// Build with +define+VGA_UPSCALE2X_EN to exercise the upscaled address map.
// The vertical counter (and matching line base) of each DUT is forced once to
// skip ahead, keeping the run short.
module tb_vga_frame_reader;

  localparam int AW = 19;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n;
  logic rst_b_n;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] rdaddr_a, rdaddr_b;
  logic rden_a, nblank_a, hsync_a, vsync_a, fs_a;
  logic rden_b, nblank_b, hsync_b, vsync_b, fs_b;

  vga_frame_reader #(.RD_LAT(1), .ADDR_W(AW)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .rdaddr(rdaddr_a), .rden(rden_a),
    .Nblank(nblank_a), .hsync(hsync_a), .vsync(vsync_a), .frame_start(fs_a)
  );

  vga_frame_reader #(.RD_LAT(3), .ADDR_W(AW)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .rdaddr(rdaddr_b), .rden(rden_b),
    .Nblank(nblank_b), .hsync(hsync_b), .vsync(vsync_b), .frame_start(fs_b)
  );

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected read address for display line/pixel.
  function automatic logic [AW-1:0] exp_addr(input int line, input int x);
`ifdef VGA_UPSCALE2X_EN
    return AW'((line / 2) * 320 + x / 2);
`else
    return AW'(line * 640 + x);
`endif
  endfunction

  task automatic push_line(input int line);
    for (int x = 0; x < 640; x++) exp_q.push_back(exp_addr(line, x));
  endtask

  task automatic check_reset_vals(input string tag, input logic [AW-1:0] a, input logic rd,
                                  input logic nb, input logic hs, input logic vs, input logic fs);
    check({tag, "_rdaddr"}, a, 0);
    check({tag, "_rden"}, rd, 0);
    check({tag, "_nblank"}, nb, 0);
    check({tag, "_hsync"}, hs, 1);
    check({tag, "_vsync"}, vs, 1);
    check({tag, "_frame_start"}, fs, 0);
  endtask

  // ---------------- address scoreboard (dut_a) ----------------
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] last_exp = '0;
  bit cmp_prev = 1'b0;

  always @(negedge clk) begin
    if (rden_a && exp_q.size() != 0) begin
      last_exp = exp_q.pop_front();
      check("rdaddr", rdaddr_a, last_exp);
      cmp_prev = 1'b1;
    end else begin
      if (cmp_prev && !rden_a) check("rdaddr_hold", rdaddr_a, last_exp);
      cmp_prev = 1'b0;
    end
  end

  // ---------------- timing monitor (dut_a) ----------------
  logic nb_p = 1'b0, hs_p = 1'b1, vs_p = 1'b1, rd_p = 1'b0, fs_p = 1'b0;
  longint t_rd = 0, t_nb = -1, t_hs = 0, t_vsf = 0, t_vsr = 0, t_fs = 0;
  bit vs_pend = 1'b0, vs_rise_seen = 1'b0, vs_seen = 1'b0;
  int nb_lines_pre_vs = 0, fs_cnt = 0, vs_cnt = 0;

  always @(negedge clk) begin
    if (rst_a_n) begin
      if (rden_a && !rd_p) t_rd = cyc;
      if (nblank_a && !nb_p) begin
        check("nb_after_rden", cyc - t_rd, 1);
        if (t_nb >= 0) begin
          if (vs_pend) begin
            check("frame_gap", cyc - t_nb, 36800);
            check("nb_after_vsync", cyc - t_vsr, 26400);
            vs_pend = 1'b0;
          end else begin
            check("line_period", cyc - t_nb, 800);
          end
        end
        t_nb = cyc;
        if (!vs_seen) nb_lines_pre_vs++;
      end
      if (!nblank_a && nb_p) check("nb_high", cyc - t_nb, 640);
      if (!hsync_a && hs_p) begin
        if (cyc - t_nb < 800) check("hs_offset", cyc - t_nb, 656);
        t_hs = cyc;
      end
      if (hsync_a && !hs_p) check("hs_low", cyc - t_hs, 96);
      if (!vsync_a && vs_p) begin
        check("vs_after_nb", cyc - t_nb, 8800);
        t_vsf = cyc;
        vs_seen = 1'b1;
        vs_cnt++;
      end
      if (vsync_a && !vs_p) begin
        check("vs_low", cyc - t_vsf, 1600);
        t_vsr = cyc;
        vs_pend = 1'b1;
        vs_rise_seen = 1'b1;
      end
      if (fs_a && !fs_p) begin
        fs_cnt++;
        t_fs = cyc;
        if (vs_rise_seen) check("fs_after_vsync", cyc - t_vsr, 26399);
      end
      if (!fs_a && fs_p) check("fs_width", cyc - t_fs, 1);
    end
    nb_p = nblank_a; hs_p = hsync_a; vs_p = vsync_a; rd_p = rden_a; fs_p = fs_a;
  end

  // ---------------- driver ----------------
  longint rel_cyc = 0;
  longint rel_b = 0;

  task automatic wait_edge(input longint base, input longint k);
    while (cyc - base < k) @(negedge clk);
  endtask

  initial begin
    int fs_seen, first_k, glitch, nb_b_j;
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_reset_vals("rst_a", rdaddr_a, rden_a, nblank_a, hsync_a, vsync_a, fs_a);
    check_reset_vals("rst_b", rdaddr_b, rden_b, nblank_b, hsync_b, vsync_b, fs_b);

    push_line(0);
    push_line(1);
    push_line(2);
    rel_cyc = cyc;
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;

    // frame_start: exactly one pulse in the first two edges, on the first.
    fs_seen = 0;
    first_k = 0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (fs_a) begin
        fs_seen++;
        if (first_k == 0) first_k = k;
      end
    end
    check("fs_once", fs_seen, 1);
    check("fs_first_edge", first_k, 1);

    // dut_b: move to line 100 at h=100, then reset it at h=300.
    wait_edge(rel_cyc, 1700);
    force dut_b.u_sync.r_v = 10'd100;
    wait_edge(rel_cyc, 1701);
    release dut_b.u_sync.r_v;
    wait_edge(rel_cyc, 1899);
    check("b_rden_pre", rden_b, 1);
    wait_edge(rel_cyc, 1900);
    rst_b_n = 1'b0;
    #1;
    check_reset_vals("midrst_b", rdaddr_b, rden_b, nblank_b, hsync_b, vsync_b, fs_b);
    wait_edge(rel_cyc, 1905);
    rst_b_n = 1'b1;
    rel_b = cyc;
    wait_edge(rel_b, 1);
    check("b_rden_post", rden_b, 1);
    check("b_rdaddr_post", rdaddr_b, 0);
    check("b_fs_post", fs_b, 1);
    glitch = 0;
    nb_b_j = 0;
    for (int j = 1; j <= 650; j++) begin
      if (j > 1) @(negedge clk);
      if (!hsync_b || !vsync_b) glitch++;
      if (nblank_b && nb_b_j == 0) nb_b_j = j;
    end
    check("b_sync_glitch", glitch, 0);
    check("b_nb_lat", nb_b_j - 1, 3);

    // dut_a: skip from line 4 (h=700, blanking) to line 477.
    wait_edge(rel_cyc, 3900);
    check("addr_q_drained", exp_q.size(), 0);
    force dut_a.u_sync.r_v = 10'd477;
    force dut_a.r_line_base = exp_addr(477, 0);
    wait_edge(rel_cyc, 3901);
    release dut_a.u_sync.r_v;
    release dut_a.r_line_base;
    push_line(478);
    push_line(479);
    push_line(0);

    while (exp_q.size() != 0 && cyc - rel_cyc < 50000) @(negedge clk);
    check("addr_q_empty", exp_q.size(), 0);
    repeat (10) @(negedge clk);
    check("nb_lines_before_vsync", nb_lines_pre_vs, 7);
    check("fs_count", fs_cnt, 2);
    check("vsync_count", vs_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
# vga_frame_reader

Generates 640x480@60 Hz VGA timing from the 25 MHz pixel clock and issues frame-buffer read addresses in raster order. It delays `Nblank`/`hsync`/`vsync` by the frame-buffer read latency so they arrive aligned with the returned RGB444 word. It sits between the camera frame buffer (dual-port BRAM read side) and the RGB444→RGB888 output stage, which consumes `Nblank` directly.

## Interface
- `RD_LAT`, 1: frame-buffer read latency in clocks, from `rdaddr` to valid data; legal values 1..3.
- `ADDR_W`, 17: `rdaddr` width. Must be ≥17 with upscale, ≥19 without.
- `clk`  in  1  25 MHz pixel clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rdaddr`  out  ADDR_W  frame-buffer read address.
- `rden`  out  1  read enable; high only for active-region addresses.
- `Nblank`  out  1  display-valid, aligned with frame-buffer data.
- `hsync`  out  1  horizontal sync, active low, aligned with `Nblank`.
- `vsync`  out  1  vertical sync, active low, aligned with `Nblank`.
- `frame_start`  out  1  one-cycle pulse when address 0 of a frame is issued.

## Operation
- Horizontal counter `h` runs 0..799: active 0..639, front porch 640..655, sync 656..751, back porch 752..799.
- Vertical counter `v` runs 0..524. It increments when `h` wraps: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
- Stage 0 is the counters. All outputs are registered from stage 0.
  - `rden` = (h<640 && v<480), delayed 1 cycle.
  - `hsync`, `vsync` and `Nblank` are delayed 1+RD_LAT cycles through a shift register.
- Addressing uses no multiplier. It uses an incrementing `addr` plus a `line_base` register.
  - `addr` loads `line_base` at h=799.
  - `addr` advances during active pixels per the Configuration rules.
- `rdaddr` holds its last value outside the active region. Only `rden` qualifies it.
- `frame_start` is high on the same cycle as the first `rden` of line 0 (`rdaddr`=0).
- `rst_n` low at any time, including mid-line: all counters, `addr`, `line_base` and the delay pipeline clear immediately. After release, scanning restarts at (h,v)=(0,0).

## Timing
- Reset values: `rdaddr`=0, `rden`=0, `Nblank`=0, `hsync`=1, `vsync`=1, `frame_start`=0.
  - The delay pipeline resets to the inactive values (1,1,0), so no spurious sync pulses occur after reset.
- First clock edge after release: counters at (0,0). One edge later: `rden`=1 and `frame_start`=1. `Nblank` rises RD_LAT cycles after `rden`.
- Line period is 800 clocks, frame period is 420000 clocks.
- `Nblank` is high for 640 consecutive clocks per active line.
- `hsync` falls 656 clocks after `Nblank` rises and stays low for 96 clocks.
- `vsync` is low for exactly 1600 clocks, covering lines 490–491.
- `Nblank`, `hsync` and `vsync` always keep mutual alignment. Only their offset relative to `rden` equals RD_LAT.

## Configuration
- `VGA_UPSCALE2X_EN` defined: the frame buffer is 320x240, upscaled 2x.
  - `addr` increments on odd active `h` only, so each address is issued for 2 consecutive pixels.
  - `line_base` advances by 320 at h=799 of odd lines only, so each line is read twice.
  - `line_base` clears at v=524. The last address is 76799.
- Not defined: the frame buffer is 640x480, read 1:1.
  - `addr` increments every active pixel.
  - `line_base` advances by 640 every active line. The last address is 307199.
- The macro only changes the address increment conditions. Sync timing is identical in both modes.

## Structure
- Shared package `vga_pkg`:
  - H/V active, front-porch, sync and back-porch constants, plus totals.
  - Source frame width/height constants for both modes.
  - Sync polarity constant.
- One sub-module `vga_sync_gen`: h/v counters, raw `hsync`/`vsync`/`active` decode, and the `line_wrap`/`frame_wrap` strobes.
- The top level holds address generation, the `rden`/`frame_start` registers and the RD_LAT delay pipeline.

## Test plan
- Reset check: hold `rst_n` low for 10 clocks → all outputs at reset values. After release, `frame_start` pulses exactly once within 2 clocks and every 420000 clocks after that.
- Line timing, RD_LAT=1: measure per line → `Nblank` high 640, `hsync` low 96 starting 656 after the `Nblank` rise, line period 800, `Nblank` rise exactly 1 cycle after `rden` rise.
- Frame timing: count lines → 480 lines with `Nblank`, `vsync` low for 1600 clocks starting at line 490, period 525 lines.
- Upscale address sequence (`VGA_UPSCALE2X_EN`):
  - line 0 `rdaddr` = 0,0,1,1,…,319,319;
  - line 1 repeats line 0;
  - line 2 starts at 320;
  - the last `rden` address of the frame is 76799.
- 1:1 mode (macro off): line 1 starts at 640, last address 307199, no address repeats.
- Reset mid-line with RD_LAT=3: assert `rst_n` at h=300, v=100 → outputs go to reset values asynchronously. After release, the next `rdaddr` is 0 with `frame_start`=1, and `hsync`/`vsync` show no glitch.
